// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: ID/EX hazard inputs in, stage controls and debug counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       id_r1_addr;
    logic [2:0]       id_r2_addr;
    logic             id_uses_r1;
    logic             id_uses_r2;
    logic             id_uses_flags;
    logic             id_branch_taken;
    logic             id_halt;
    logic [2:0]       ex_dest;
    logic             ex_reg_write;
    logic             ex_is_load;
    logic             ex_flag_write;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             halted;
    logic             busy_init;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_r1_addr, id_r2_addr, id_uses_r1, id_uses_r2, id_uses_flags,
               id_branch_taken, id_halt, ex_dest, ex_reg_write, ex_is_load, ex_flag_write,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, halted, busy_init,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_r1_addr, id_r2_addr, id_uses_r1, id_uses_r2, id_uses_flags,
               id_branch_taken, id_halt, ex_dest, ex_reg_write, ex_is_load, ex_flag_write,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, halted, busy_init,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: start-up hold, load/flag-use stalls,
// branch squash, halt parking and saturating stall/flush event counters.
//
// state | meaning
// INIT  | pipeline frozen for INIT_CYCLES edges after reset or init
// RUN   | normal flow; Mealy stall / flush / halt decisions from ID and EX
// HALT  | core parked; only init or rst leaves
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [ICW-1:0]   INIT_LOAD = ICW'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [ICW-1:0]   init_cnt, init_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
    logic [CNT_W-1:0] flush_cnt, flush_cnt_nxt;

    logic src1_hit, src2_hit;
    logic load_hz, flag_hz, stall;

    logic pc_en, if_id_en, if_id_flush, id_ex_bubble, halted, busy_init;

    // Register 0 is compared like any other address.
    always_comb begin
        src1_hit = bus.id_uses_r1 && (bus.id_r1_addr == bus.ex_dest);
        src2_hit = bus.id_uses_r2 && (bus.id_r2_addr == bus.ex_dest);
        load_hz  = bus.ex_is_load && bus.ex_reg_write && (src1_hit || src2_hit);
        flag_hz  = bus.id_uses_flags && bus.ex_flag_write;
        stall    = load_hz || flag_hz;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_INIT;
            init_cnt  <= INIT_LOAD;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        init_cnt_nxt  = init_cnt;
        stall_cnt_nxt = stall_cnt;
        flush_cnt_nxt = flush_cnt;
        if (init) begin
            state_nxt     = ST_INIT;
            init_cnt_nxt  = INIT_LOAD;
            stall_cnt_nxt = '0;
            flush_cnt_nxt = '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        init_cnt_nxt = init_cnt - ICW'(1);
                    end
                end
                ST_RUN: begin
                    // Stall outranks branch and halt; those are re-seen next cycle.
                    if (stall) begin
                        if (stall_cnt != CNT_MAX) begin
                            stall_cnt_nxt = stall_cnt + CNT_W'(1);
                        end
                    end else if (bus.id_branch_taken) begin
                        if (flush_cnt != CNT_MAX) begin
                            flush_cnt_nxt = flush_cnt + CNT_W'(1);
                        end
                    end else if (bus.id_halt) begin
                        state_nxt = ST_HALT;
                    end
                end
                ST_HALT: begin
                    state_nxt = ST_HALT;
                end
                default: begin
                    state_nxt = ST_INIT;
                end
            endcase
        end
    end

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b1;
        halted       = 1'b0;
        busy_init    = 1'b0;
        case (state)
            ST_INIT: begin
                busy_init = 1'b1;
            end
            ST_RUN: begin
                if (stall) begin
                    id_ex_bubble = 1'b1;
                end else if (bus.id_branch_taken) begin
                    pc_en        = 1'b1;
                    if_id_en     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b0;
                end else if (bus.id_halt) begin
                    id_ex_bubble = 1'b1;
                end else begin
                    pc_en        = 1'b1;
                    if_id_en     = 1'b1;
                    id_ex_bubble = 1'b0;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                busy_init = 1'b1;
            end
        endcase
    end

    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.halted       = halted;
    assign bus.busy_init    = busy_init;
    assign bus.stall_cnt    = stall_cnt;
    assign bus.flush_cnt    = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed start-up/hazard/halt/saturation/reset cases plus
// randomized traffic, all outputs compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int INIT_CYCLES = 8;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = 15;
    localparam int M_INIT      = 0;
    localparam int M_RUN       = 1;
    localparam int M_HALT      = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic init = 1'b0;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus();

    pipeline_hazard_ctrl #(
        .INIT_CYCLES (INIT_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .init (init),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: operating mode, remaining frozen edges, and event totals.
    int m_mode;
    int m_hold;
    int m_stall;
    int m_flush;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_mode  = M_INIT;
        m_hold  = INIT_CYCLES;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic idle_inputs();
        bus.id_r1_addr      = 3'd0;
        bus.id_r2_addr      = 3'd0;
        bus.id_uses_r1      = 1'b0;
        bus.id_uses_r2      = 1'b0;
        bus.id_uses_flags   = 1'b0;
        bus.id_branch_taken = 1'b0;
        bus.id_halt         = 1'b0;
        bus.ex_dest         = 3'd0;
        bus.ex_reg_write    = 1'b0;
        bus.ex_is_load      = 1'b0;
        bus.ex_flag_write   = 1'b0;
        init                = 1'b0;
    endtask

    task automatic rand_inputs(input bit allow_init);
        bus.ex_dest         = 3'($urandom_range(7));
        bus.id_r1_addr      = ($urandom_range(1) == 0) ? bus.ex_dest : 3'($urandom_range(7));
        bus.id_r2_addr      = ($urandom_range(1) == 0) ? bus.ex_dest : 3'($urandom_range(7));
        bus.id_uses_r1      = ($urandom_range(99) < 50);
        bus.id_uses_r2      = ($urandom_range(99) < 50);
        bus.id_uses_flags   = ($urandom_range(99) < 25);
        bus.id_branch_taken = ($urandom_range(99) < 20);
        bus.id_halt         = ($urandom_range(99) < 4);
        bus.ex_reg_write    = ($urandom_range(99) < 60);
        bus.ex_is_load      = ($urandom_range(99) < 30);
        bus.ex_flag_write   = ($urandom_range(99) < 30);
        init                = allow_init && ($urandom_range(99) < 2);
    endtask

    task automatic compare();
        int  e_pc, e_en, e_fl, e_bub, e_halt, e_busy;
        bit  chk_fl, ld, st;
        ld = 1'b0;
        if (bus.ex_is_load && bus.ex_reg_write) begin
            if (bus.id_uses_r1 && bus.id_r1_addr == bus.ex_dest) ld = 1'b1;
            if (bus.id_uses_r2 && bus.id_r2_addr == bus.ex_dest) ld = 1'b1;
        end
        st = ld || (bus.id_uses_flags && bus.ex_flag_write);
        chk_fl = 1'b1;
        e_pc = 0; e_en = 0; e_fl = 0; e_bub = 1; e_halt = 0; e_busy = 0;
        if (m_mode == M_INIT) begin
            e_busy = 1;
        end else if (m_mode == M_HALT) begin
            e_halt = 1;
            chk_fl = 1'b0;
        end else if (st) begin
            e_bub = 1;
        end else if (bus.id_branch_taken) begin
            e_pc = 1; e_en = 1; e_fl = 1; e_bub = 0;
        end else if (bus.id_halt) begin
            chk_fl = 1'b0;
        end else begin
            e_pc = 1; e_en = 1; e_bub = 0;
        end
        chk("pc_en", int'(bus.pc_en), e_pc);
        chk("if_id_en", int'(bus.if_id_en), e_en);
        if (chk_fl) chk("if_id_flush", int'(bus.if_id_flush), e_fl);
        chk("id_ex_bubble", int'(bus.id_ex_bubble), e_bub);
        chk("halted", int'(bus.halted), e_halt);
        chk("busy_init", int'(bus.busy_init), e_busy);
        chk("stall_cnt", int'(bus.stall_cnt), m_stall);
        chk("flush_cnt", int'(bus.flush_cnt), m_flush);
        if (rst) begin
            if (init) begin
                m_mode  = M_INIT;
                m_hold  = INIT_CYCLES;
                m_stall = 0;
                m_flush = 0;
            end else if (m_mode == M_INIT) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (st) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
                else if (bus.id_branch_taken) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
                else if (bus.id_halt) m_mode = M_HALT;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_hazard(input bit use_r2);
        idle_inputs();
        bus.ex_is_load   = 1'b1;
        bus.ex_reg_write = 1'b1;
        bus.ex_dest      = 3'd3;
        bus.id_uses_r2   = use_r2;
        bus.id_r2_addr   = 3'd3;
    endtask

    initial begin
        idle_inputs();
        reset_model();
        #1;
        chk("rst_pc_en", int'(bus.pc_en), 0);
        chk("rst_bubble", int'(bus.id_ex_bubble), 1);
        chk("rst_busy", int'(bus.busy_init), 1);
        chk("rst_stall_cnt", int'(bus.stall_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Start-up hold: eight frozen edges, then flowing.
        for (int i = 0; i < INIT_CYCLES; i++) begin
            chk("startup_busy", int'(bus.busy_init), 1);
            chk("startup_pc_en", int'(bus.pc_en), 0);
            tick();
        end
        chk("run_busy", int'(bus.busy_init), 0);
        chk("run_pc_en", int'(bus.pc_en), 1);

        // Load-use on r2, then the same without r2 in use.
        set_load_hazard(1'b1);
        #1;
        chk("load_use_pc_en", int'(bus.pc_en), 0);
        chk("load_use_bubble", int'(bus.id_ex_bubble), 1);
        tick();
        idle_inputs();
        #1;
        chk("load_use_cleared_pc_en", int'(bus.pc_en), 1);
        chk("load_use_stall_cnt", int'(bus.stall_cnt), 1);
        set_load_hazard(1'b0);
        #1;
        chk("no_use_pc_en", int'(bus.pc_en), 1);
        tick();
        chk("no_use_stall_cnt", int'(bus.stall_cnt), 1);

        // Flag hazard masks a simultaneous branch; branch squashes next cycle.
        idle_inputs();
        bus.id_uses_flags   = 1'b1;
        bus.ex_flag_write   = 1'b1;
        bus.id_branch_taken = 1'b1;
        #1;
        chk("flag_hz_flush", int'(bus.if_id_flush), 0);
        chk("flag_hz_pc_en", int'(bus.pc_en), 0);
        tick();
        chk("flag_hz_stall_cnt", int'(bus.stall_cnt), 2);
        bus.ex_flag_write = 1'b0;
        #1;
        chk("branch_flush", int'(bus.if_id_flush), 1);
        tick();
        chk("branch_flush_cnt", int'(bus.flush_cnt), 1);

        // Halt parks the core until init.
        idle_inputs();
        bus.id_halt = 1'b1;
        #1;
        chk("halt_pc_en", int'(bus.pc_en), 0);
        chk("halt_bubble", int'(bus.id_ex_bubble), 1);
        tick();
        for (int i = 0; i < 20; i++) begin
            rand_inputs(1'b0);
            #1;
            chk("parked_halted", int'(bus.halted), 1);
            chk("parked_pc_en", int'(bus.pc_en), 0);
            tick();
        end
        idle_inputs();
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("reinit_busy", int'(bus.busy_init), 1);
        chk("reinit_stall_cnt", int'(bus.stall_cnt), 0);
        chk("reinit_flush_cnt", int'(bus.flush_cnt), 0);
        for (int i = 0; i < INIT_CYCLES; i++) tick();
        chk("reinit_run_pc_en", int'(bus.pc_en), 1);
        chk("reinit_run_busy", int'(bus.busy_init), 0);

        // Counter saturation with a held hazard.
        set_load_hazard(1'b1);
        for (int i = 0; i < 20; i++) tick();
        chk("stall_saturated", int'(bus.stall_cnt), 15);

        // Asynchronous reset between edges while stalled.
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_pc_en", int'(bus.pc_en), 0);
        chk("async_rst_bubble", int'(bus.id_ex_bubble), 1);
        chk("async_rst_busy", int'(bus.busy_init), 1);
        chk("async_rst_stall_cnt", int'(bus.stall_cnt), 0);
        reset_model();
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < INIT_CYCLES; i++) tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs(1'b1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
